// File: rtl/pipe_chain_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_chain_if
//  Description : Upstream/downstream ready-valid bundle for pipe_chain.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_chain_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    // master drives words in and consumes them at the output
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_chain
//  Description : DEPTH-stage ready/valid register chain with bubble collapsing,
//                backpressure, synchronous flush, occupancy count, zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_chain #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          flush,
    pipe_chain_if.slave        bus,
    output logic [CW-1:0]      count
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [CW-1:0]               r_count;

    logic [DEPTH-1:0]            w_rdy;
    logic [DEPTH-1:0]            w_src_valid;
    logic [DEPTH-1:0][WIDTH-1:0] w_src_data;
    logic                        w_accept;
    logic                        w_xfer;
    logic                        w_out_valid;

    // A stage can take a word if out_ready is high or any stage at or below
    // it (towards the output) is empty; this is the unrolled ready chain.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
        assign w_rdy[i] = bus.out_ready | ~(&r_valid[DEPTH-1:i]);
    end

    always_comb begin
        w_src_valid    = '0;
        w_src_data     = '0;
        w_src_valid[0] = bus.in_valid;
        w_src_data[0]  = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_valid[i] = r_valid[i-1];
            w_src_data[i]  = r_data[i-1];
        end
    end

    assign w_out_valid   = r_valid[DEPTH-1] & ~flush;
    assign bus.in_ready  = w_rdy[0] & ~flush;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_data[DEPTH-1];
    assign bus.out_zero  = w_out_valid && (r_data[DEPTH-1] == '0);
    assign count         = r_count;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_xfer   = w_out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            // A ready stage takes whatever its source holds; a blocked stage keeps its word.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_valid[i] <= w_src_valid[i];
                    if (w_src_valid[i]) begin
                        r_data[i] <= w_src_data[i];
                    end
                end
            end
            if (w_accept && !w_xfer) begin
                r_count <= r_count + CW'(1);
            end else if (!w_accept && w_xfer) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_chain
//  Description : Directed vector bench for pipe_chain (WIDTH=16, DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_chain;

    localparam int c_WIDTH = 16;
    localparam int c_DEPTH = 4;
    localparam int c_NVEC  = 40;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [2:0] count;

    pipe_chain_if #(.WIDTH(c_WIDTH)) bus ();

    pipe_chain #(
        .WIDTH (c_WIDTH),
        .DEPTH (c_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_oz;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [c_NVEC];
    int   n_pass;
    int   n_total;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [15:0] d, input logic ordy);
        reset         = r;
        flush         = f;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic check_all(input int idx, input logic ir, input logic ov, input logic [15:0] od,
                             input logic oz, input logic [2:0] cnt);
        chk("in_ready",  idx, 32'(bus.in_ready),  32'(ir));
        chk("out_valid", idx, 32'(bus.out_valid), 32'(ov));
        chk("out_data",  idx, 32'(bus.out_data),  32'(od));
        chk("out_zero",  idx, 32'(bus.out_zero),  32'(oz));
        chk("count",     idx, 32'(count),         32'(cnt));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        //                rst   fl    iv    id        ordy   ir    ov    od        oz    cnt
        // reset and first word latency
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 3'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1111, 1'b0, 3'd0};
        // backpressure: six offered, four taken, one swap at full
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'hA001, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 3'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'hA002, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 3'd2};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'hA003, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 3'd3};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 16'hA004, 1'b0, 1'b0, 1'b1, 16'hA001, 1'b0, 3'd4};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 16'hA005, 1'b0, 1'b0, 1'b1, 16'hA001, 1'b0, 3'd4};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 16'hA005, 1'b0, 1'b0, 1'b1, 16'hA001, 1'b0, 3'd4};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 16'hA005, 1'b1, 1'b1, 1'b1, 16'hA002, 1'b0, 3'd4};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 16'hA006, 1'b0, 1'b0, 1'b1, 16'hA002, 1'b0, 3'd4};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA003, 1'b0, 3'd3};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA004, 1'b0, 3'd2};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA005, 1'b0, 3'd1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hA005, 1'b0, 3'd0};
        // bubble collapse with out_ready low
        tbl[19] = '{1'b0, 1'b0, 1'b1, 16'hB001, 1'b0, 1'b1, 1'b0, 16'hA005, 1'b0, 3'd1};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA005, 1'b0, 3'd1};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA005, 1'b0, 3'd1};
        tbl[22] = '{1'b0, 1'b0, 1'b1, 16'hB002, 1'b0, 1'b1, 1'b1, 16'hB001, 1'b0, 3'd2};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hB001, 1'b0, 3'd2};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hB001, 1'b0, 3'd2};
        tbl[25] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hB001, 1'b0, 3'd2};
        tbl[26] = '{1'b0, 1'b0, 1'b1, 16'hB003, 1'b0, 1'b1, 1'b1, 16'hB001, 1'b0, 3'd3};
        // flush at count=3, then zero word traverses
        tbl[27] = '{1'b0, 1'b1, 1'b1, 16'hB004, 1'b1, 1'b0, 1'b0, 16'hB001, 1'b0, 3'd0};
        tbl[28] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hB001, 1'b0, 3'd1};
        tbl[29] = '{1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 16'hB001, 1'b0, 3'd2};
        tbl[30] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hB001, 1'b0, 3'd2};
        tbl[31] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 3'd2};
        tbl[32] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 3'd1};
        tbl[33] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0, 3'd0};
        // fill, then reset+flush together while full
        tbl[34] = '{1'b0, 1'b0, 1'b1, 16'hE001, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, 3'd1};
        tbl[35] = '{1'b0, 1'b0, 1'b1, 16'hE002, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, 3'd2};
        tbl[36] = '{1'b0, 1'b0, 1'b1, 16'hE003, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b0, 3'd3};
        tbl[37] = '{1'b0, 1'b0, 1'b1, 16'hE004, 1'b0, 1'b0, 1'b1, 16'hE001, 1'b0, 3'd4};
        tbl[38] = '{1'b1, 1'b1, 1'b1, 16'hE005, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0};
        tbl[39] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0};

        for (int v = 0; v < c_NVEC; v++) begin
            drive(tbl[v].rst, tbl[v].fl, tbl[v].iv, tbl[v].id, tbl[v].ordy);
            @(posedge clk);
            @(negedge clk);
            check_all(v, tbl[v].e_ir, tbl[v].e_ov, tbl[v].e_od, tbl[v].e_oz, tbl[v].e_cnt);
        end

        // streaming 0x0001..0x0010 back-to-back, then drain
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b0, 1'b1, 16'(k), 1'b1);
            @(posedge clk);
            @(negedge clk);
            chk("stream_count", 100 + k, 32'(count), (k < 4) ? k : 4);
            chk("stream_valid", 100 + k, 32'(bus.out_valid), (k < 4) ? 0 : 1);
            if (k >= 4) begin
                chk("stream_data", 100 + k, 32'(bus.out_data), k - 3);
            end
        end
        for (int j = 1; j <= 4; j++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
            @(posedge clk);
            @(negedge clk);
            chk("drain_count", 200 + j, 32'(count), 4 - j);
            chk("drain_valid", 200 + j, 32'(bus.out_valid), (j < 4) ? 1 : 0);
            if (j < 4) begin
                chk("drain_data", 200 + j, 32'(bus.out_data), 13 + j);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
